branch_resolve_unit: RTL and testbench

Resolves the branches of both issue ways against the prediction metadata fetch attached to them (prediction bit, GHPT index, GHR snapshot, BTB index, predicted target). Issues the pipeline Flush, redirect PC and GHR restore on a misprediction. Serialises predictor-table updates through a small queue onto the single-ported GHPT/BTB write port. It sits at the execute-stage end of the prediction path, opposite the fetch-side predictor.

---
 rtl/bru_pkg.sv | 16 +
 rtl/bru_update_fifo.sv | 74 +++++++
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared widths and the predictor-update payload for the branch resolve unit.
package bru_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned GHR_W  = 5;

  typedef struct packed {
    logic [IDX_W-1:0]  ghpt_idx;
    logic              taken;
    logic [IDX_W-1:0]  btb_idx;
    logic [ADDR_W-1:0] target;
    logic              btb_write;
  } upd_entry_t;

endpackage

// File: rtl/bru_update_fifo.sv
// Dual-push / single-pop circular queue of predictor updates.
// Push port 0 is always the older entry; a push beyond capacity is dropped and latched.
module bru_update_fifo
  import bru_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       push0_i,
  input  upd_entry_t push0_data_i,
  input  logic       push1_i,
  input  upd_entry_t push1_data_i,
  input  logic       pop_i,
  output upd_entry_t head_o,
  output logic       valid_o,
  output logic       stall_o,
  output logic       overflow_err_o
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  upd_entry_t       mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             pop_c, acc0_c, acc1_c;
  logic [CNT_W-1:0] free_c;
  logic [PTR_W-1:0] idx1_c;
  logic [1:0]       n_push_c;

  // Free slots this cycle include the one vacated by a simultaneous pop.
  always_comb begin
    pop_c      = pop_i & (count_q != '0);
    free_c     = CNT_W'(QDEPTH) - count_q + CNT_W'(pop_c);
    acc0_c     = push0_i & (free_c >= CNT_W'(1));
    acc1_c     = push1_i & (free_c >= (acc0_c ? CNT_W'(2) : CNT_W'(1)));
    idx1_c     = acc0_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    n_push_c   = {1'b0, acc0_c} + {1'b0, acc1_c};
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(n_push_c) - CNT_W'(pop_c);
    overflow_d = overflow_q | (push0_i & ~acc0_c) | (push1_i & ~acc1_c);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: nothing is presented while count is zero.
  always_ff @(posedge clk) begin
    if (acc0_c) mem_q[wr_ptr_q] <= push0_data_i;
    if (acc1_c) mem_q[idx1_c]   <= push1_data_i;
  end

  assign head_o         = mem_q[rd_ptr_q];
  assign valid_o        = (count_q != '0);
  assign stall_o        = (CNT_W'(QDEPTH) - count_q) < CNT_W'(2);
  assign overflow_err_o = overflow_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution for two issue ways: flush/redirect and queued predictor training.
// Optional BTB training is enabled by defining BRU_BTB_UPDATE_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned ADDR_W = bru_pkg::ADDR_W,
  parameter int unsigned IDX_W  = bru_pkg::IDX_W,
  parameter int unsigned GHR_W  = bru_pkg::GHR_W,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              w0_valid,
  input  logic              w1_valid,
  input  logic              w0_is_branch,
  input  logic              w1_is_branch,
  input  logic              w0_prediction,
  input  logic              w1_prediction,
  input  logic              w0_taken,
  input  logic              w1_taken,
  input  logic [ADDR_W-1:0] w0_pc,
  input  logic [ADDR_W-1:0] w1_pc,
  input  logic [ADDR_W-1:0] w0_pred_target,
  input  logic [ADDR_W-1:0] w1_pred_target,
  input  logic [ADDR_W-1:0] w0_target,
  input  logic [ADDR_W-1:0] w1_target,
  input  logic [IDX_W-1:0]  w0_ghpt_idx,
  input  logic [IDX_W-1:0]  w1_ghpt_idx,
  input  logic [GHR_W-1:0]  w0_ghr,
  input  logic [GHR_W-1:0]  w1_ghr,
  input  logic [IDX_W-1:0]  w0_btb_idx,
  input  logic [IDX_W-1:0]  w1_btb_idx,
  input  logic              oldest,
  output logic              Flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [GHR_W-1:0]  ghr_restore,
  output logic              stall,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [IDX_W-1:0]  upd_ghpt_idx,
  output logic              upd_taken,
  output logic              upd_btb_write,
  output logic [IDX_W-1:0]  upd_btb_idx,
  output logic [ADDR_W-1:0] upd_btb_target
);

  logic              res0_c, res1_c, mis0_c, mis1_c;
  logic              o_res_c, o_mis_c, y_res_c, y_mis_c;
  logic [ADDR_W-1:0] cpc0_c, cpc1_c;
  logic [GHR_W-1:0]  ghr0_c, ghr1_c;
  upd_entry_t        e0_c, e1_c, o_ent_c, y_ent_c;
  logic              push0_c, push1_c;
  upd_entry_t        push0_data_c;
  logic              flush_src_c;

  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [GHR_W-1:0]  ghr_restore_q, ghr_restore_d;

  upd_entry_t        head;
  logic              overflow_err;

  assign res0_c = w0_valid & w0_is_branch;
  assign res1_c = w1_valid & w1_is_branch;
  assign mis0_c = res0_c & ((w0_prediction != w0_taken) | (w0_taken & (w0_pred_target != w0_target)));
  assign mis1_c = res1_c & ((w1_prediction != w1_taken) | (w1_taken & (w1_pred_target != w1_target)));

  assign cpc0_c = w0_taken ? w0_target : w0_pc + ADDR_W'(4);
  assign cpc1_c = w1_taken ? w1_target : w1_pc + ADDR_W'(4);
  assign ghr0_c = {w0_ghr[GHR_W-2:0], w0_taken};
  assign ghr1_c = {w1_ghr[GHR_W-2:0], w1_taken};

  // Per-way update payloads; BTB fields stay zero when BTB training is disabled.
  always_comb begin
    e0_c          = '0;
    e1_c          = '0;
    e0_c.ghpt_idx = w0_ghpt_idx;
    e0_c.taken    = w0_taken;
    e1_c.ghpt_idx = w1_ghpt_idx;
    e1_c.taken    = w1_taken;
`ifdef BRU_BTB_UPDATE_EN
    e0_c.btb_idx   = w0_btb_idx;
    e0_c.target    = w0_target;
    e0_c.btb_write = w0_taken;
    e1_c.btb_idx   = w1_btb_idx;
    e1_c.target    = w1_target;
    e1_c.btb_write = w1_taken;
`endif
  end

  // Older/younger view; a mispredicting older way puts the younger on the wrong path.
  always_comb begin
    o_res_c      = oldest ? res1_c : res0_c;
    o_mis_c      = oldest ? mis1_c : mis0_c;
    y_res_c      = oldest ? res0_c : res1_c;
    y_mis_c      = oldest ? mis0_c : mis1_c;
    o_ent_c      = oldest ? e1_c : e0_c;
    y_ent_c      = oldest ? e0_c : e1_c;
    push0_c      = o_res_c | (y_res_c & ~o_mis_c);
    push0_data_c = o_res_c ? o_ent_c : y_ent_c;
    push1_c      = o_res_c & y_res_c & ~o_mis_c;
    flush_src_c  = o_mis_c ? oldest : ~oldest;
  end

  always_comb begin
    flush_d       = o_mis_c | y_mis_c;
    redirect_pc_d = redirect_pc_q;
    ghr_restore_d = ghr_restore_q;
    if (flush_d) begin
      redirect_pc_d = flush_src_c ? cpc1_c : cpc0_c;
      ghr_restore_d = flush_src_c ? ghr1_c : ghr0_c;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      ghr_restore_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      ghr_restore_q <= ghr_restore_d;
    end
  end

  bru_update_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk            (clk),
    .Reset          (Reset),
    .push0_i        (push0_c),
    .push0_data_i   (push0_data_c),
    .push1_i        (push1_c),
    .push1_data_i   (y_ent_c),
    .pop_i          (upd_ready),
    .head_o         (head),
    .valid_o        (upd_valid),
    .stall_o        (stall),
    .overflow_err_o (overflow_err)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (Reset) !overflow_err);

  assign Flush        = flush_q;
  assign redirect_pc  = redirect_pc_q;
  assign ghr_restore  = ghr_restore_q;
  assign upd_ghpt_idx = head.ghpt_idx;
  assign upd_taken    = head.taken;

`ifdef BRU_BTB_UPDATE_EN
  assign upd_btb_write  = head.btb_write;
  assign upd_btb_idx    = head.btb_idx;
  assign upd_btb_target = head.target;
`else
  logic unused_btb;
  assign unused_btb     = ^{head.btb_idx, head.target, head.btb_write, w0_btb_idx, w1_btb_idx};
  assign upd_btb_write  = 1'b0;
  assign upd_btb_idx    = '0;
  assign upd_btb_target = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default QDEPTH=4).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        w0_valid = 0, w1_valid = 0, w0_is_branch = 0, w1_is_branch = 0;
  logic        w0_prediction = 0, w1_prediction = 0, w0_taken = 0, w1_taken = 0;
  logic [31:0] w0_pc = 0, w1_pc = 0, w0_pred_target = 0, w1_pred_target = 0;
  logic [31:0] w0_target = 0, w1_target = 0;
  logic [4:0]  w0_ghpt_idx = 0, w1_ghpt_idx = 0, w0_ghr = 0, w1_ghr = 0;
  logic [4:0]  w0_btb_idx = 0, w1_btb_idx = 0;
  logic        oldest = 0;
  logic        Flush, stall, upd_valid, upd_taken, upd_btb_write;
  logic        upd_ready = 0;
  logic [31:0] redirect_pc, upd_btb_target;
  logic [4:0]  ghr_restore, upd_ghpt_idx, upd_btb_idx;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit dut (
    .clk(clk), .Reset(Reset),
    .w0_valid(w0_valid), .w1_valid(w1_valid),
    .w0_is_branch(w0_is_branch), .w1_is_branch(w1_is_branch),
    .w0_prediction(w0_prediction), .w1_prediction(w1_prediction),
    .w0_taken(w0_taken), .w1_taken(w1_taken),
    .w0_pc(w0_pc), .w1_pc(w1_pc),
    .w0_pred_target(w0_pred_target), .w1_pred_target(w1_pred_target),
    .w0_target(w0_target), .w1_target(w1_target),
    .w0_ghpt_idx(w0_ghpt_idx), .w1_ghpt_idx(w1_ghpt_idx),
    .w0_ghr(w0_ghr), .w1_ghr(w1_ghr),
    .w0_btb_idx(w0_btb_idx), .w1_btb_idx(w1_btb_idx),
    .oldest(oldest),
    .Flush(Flush), .redirect_pc(redirect_pc), .ghr_restore(ghr_restore),
    .stall(stall), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_ghpt_idx(upd_ghpt_idx), .upd_taken(upd_taken),
    .upd_btb_write(upd_btb_write), .upd_btb_idx(upd_btb_idx),
    .upd_btb_target(upd_btb_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_way(input int w, input logic pred, input logic tkn,
                           input logic [31:0] pc, input logic [31:0] pt, input logic [31:0] tgt,
                           input logic [4:0] gidx, input logic [4:0] ghr, input logic [4:0] bidx);
    if (w == 0) begin
      w0_valid = 1; w0_is_branch = 1; w0_prediction = pred; w0_taken = tkn;
      w0_pc = pc; w0_pred_target = pt; w0_target = tgt;
      w0_ghpt_idx = gidx; w0_ghr = ghr; w0_btb_idx = bidx;
    end else begin
      w1_valid = 1; w1_is_branch = 1; w1_prediction = pred; w1_taken = tkn;
      w1_pc = pc; w1_pred_target = pt; w1_target = tgt;
      w1_ghpt_idx = gidx; w1_ghr = ghr; w1_btb_idx = bidx;
    end
  endtask

  task automatic clear_ways();
    w0_valid = 0; w1_valid = 0;
  endtask

  logic exp_bw;
  logic [31:0] exp_bt;
  logic [4:0] exp_bi;

  initial begin
`ifdef BRU_BTB_UPDATE_EN
    exp_bw = 1'b1; exp_bt = 32'h900; exp_bi = 5'd11;
`else
    exp_bw = 1'b0; exp_bt = 32'h0; exp_bi = 5'd0;
`endif
    step();
    step();
    check("rst_flush", Flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_ghr", ghr_restore, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_stall", stall, 0);
    Reset = 0;
    step();

    // Single w0 mispredict: predicted taken, actually not taken
    oldest = 0;
    drive_way(0, 1, 0, 32'h100, 32'h200, 32'h200, 5'd3, 5'b10110, 5'd7);
    step();
    clear_ways();
    check("a_flush", Flush, 1);
    check("a_redirect", redirect_pc, 32'h104);
    check("a_ghr", ghr_restore, 5'b01100);
    check("a_upd_valid", upd_valid, 1);
    check("a_upd_idx", upd_ghpt_idx, 3);
    check("a_upd_taken", upd_taken, 0);
    check("a_upd_bw", upd_btb_write, 0);
    step();
    check("a_flush_pulse", Flush, 0);
    check("a_hold_valid", upd_valid, 1);
    upd_ready = 1;
    step();
    check("a_drained", upd_valid, 0);
    upd_ready = 0;

    // Both mispredict, w1 older
    oldest = 1;
    drive_way(0, 0, 1, 32'h200, 32'h0, 32'h300, 5'd1, 5'b00001, 5'd2);
    drive_way(1, 0, 1, 32'h380, 32'h0, 32'h400, 5'd9, 5'b00011, 5'd4);
    step();
    clear_ways();
    check("b_flush", Flush, 1);
    check("b_redirect", redirect_pc, 32'h400);
    check("b_ghr", ghr_restore, 5'b00111);
    check("b_upd_idx", upd_ghpt_idx, 9);
    check("b_upd_taken", upd_taken, 1);
    upd_ready = 1;
    step();
    check("b_one_entry", upd_valid, 0);
    upd_ready = 0;

    // w0 older and correct, w1 mispredicts
    oldest = 0;
    drive_way(0, 1, 1, 32'h4F0, 32'h500, 32'h500, 5'd2, 5'b00000, 5'd1);
    drive_way(1, 1, 0, 32'h600, 32'h700, 32'h700, 5'd12, 5'b11111, 5'd5);
    step();
    clear_ways();
    check("c_flush", Flush, 1);
    check("c_redirect", redirect_pc, 32'h604);
    check("c_ghr", ghr_restore, 5'b11110);
    check("c_head0_idx", upd_ghpt_idx, 2);
    check("c_head0_taken", upd_taken, 1);
    upd_ready = 1;
    step();
    check("c_head1_valid", upd_valid, 1);
    check("c_head1_idx", upd_ghpt_idx, 12);
    check("c_head1_taken", upd_taken, 0);
    step();
    check("c_drained", upd_valid, 0);
    upd_ready = 0;

    // Back-to-back mispredicts
    drive_way(0, 0, 1, 32'h6F0, 32'h0, 32'h700, 5'd5, 5'b00000, 5'd0);
    step();
    check("d_flush1", Flush, 1);
    check("d_redirect1", redirect_pc, 32'h700);
    check("d_ghr1", ghr_restore, 5'b00001);
    drive_way(0, 1, 0, 32'h800, 32'h900, 32'h900, 5'd6, 5'b00001, 5'd0);
    step();
    clear_ways();
    check("d_flush2", Flush, 1);
    check("d_redirect2", redirect_pc, 32'h804);
    check("d_ghr2", ghr_restore, 5'b00010);
    check("d_head0", upd_ghpt_idx, 5);
    upd_ready = 1;
    step();
    check("d_head1", upd_ghpt_idx, 6);
    step();
    check("d_drained", upd_valid, 0);
    upd_ready = 0;

    // Fill with correct branches while predictor is not ready
    drive_way(0, 0, 0, 32'h1000, 32'h0, 32'h0, 5'd20, 5'd0, 5'd0);
    drive_way(1, 0, 0, 32'h1004, 32'h0, 32'h0, 5'd21, 5'd0, 5'd0);
    step();
    clear_ways();
    check("s_no_flush", Flush, 0);
    check("s_stall_cnt2", stall, 0);
    drive_way(0, 0, 0, 32'h1008, 32'h0, 32'h0, 5'd22, 5'd0, 5'd0);
    step();
    clear_ways();
    check("s_stall_cnt3", stall, 1);
    drive_way(1, 0, 0, 32'h100C, 32'h0, 32'h0, 5'd23, 5'd0, 5'd0);
    step();
    clear_ways();
    check("s_stall_cnt4", stall, 1);
    step();
    check("s_hold_idx", upd_ghpt_idx, 20);
    upd_ready = 1;
    step();
    check("s_pop1_idx", upd_ghpt_idx, 21);
    check("s_pop1_stall", stall, 1);
    step();
    check("s_pop2_idx", upd_ghpt_idx, 22);
    check("s_pop2_stall", stall, 0);
    step();
    check("s_pop3_idx", upd_ghpt_idx, 23);
    step();
    check("s_drained", upd_valid, 0);
    upd_ready = 0;

    // Correctly predicted taken branch: BTB fields depend on build
    drive_way(0, 1, 1, 32'h8F0, 32'h900, 32'h900, 5'd17, 5'd0, 5'd11);
    step();
    clear_ways();
    check("e_no_flush", Flush, 0);
    check("e_upd_valid", upd_valid, 1);
    check("e_upd_idx", upd_ghpt_idx, 17);
    check("e_upd_taken", upd_taken, 1);
    check("e_btb_write", upd_btb_write, exp_bw);
    check("e_btb_idx", upd_btb_idx, exp_bi);
    check("e_btb_target", upd_btb_target, exp_bt);
    upd_ready = 1;
    step();
    upd_ready = 0;

    // Reset with three entries queued and a flush pending
    drive_way(0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0);
    drive_way(1, 0, 0, 32'h14, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0);
    step();
    clear_ways();
    drive_way(0, 1, 0, 32'h40, 32'h80, 32'h80, 5'd3, 5'd0, 5'd0);
    step();
    clear_ways();
    check("r_pre_flush", Flush, 1);
    check("r_pre_stall", stall, 1);
    #2;
    Reset = 1;
    #1;
    check("r_upd_valid", upd_valid, 0);
    check("r_stall", stall, 0);
    check("r_flush", Flush, 0);
    step();
    Reset = 0;
    step();
    check("r_post_valid", upd_valid, 0);
    check("r_post_flush", Flush, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
